// File: rtl/atmega_pll_lock_det.sv
// atmega_pll_lock_det: counts synchronized PLL clock edges per reference window and tracks lock/loss.
// Define ATMEGA_PLL_LOCK_IRQ_EN to implement LOSSIE and the registered loss-of-lock irq_o.
module atmega_pll_lock_det #(
  parameter int                           BUS_ADDR_DATA_LEN = 16,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PLLLCK_ADDR       = 'h4A,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PLLREF_ADDR       = 'h4B,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PLLCNT_ADDR       = 'h4C,
  parameter int                           WINDOW_LEN        = 256,
  parameter int                           LOCK_WINDOWS      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic                         wr_i,
  input  logic                         rd_i,
  input  logic [7:0]                   bus_i,
  output logic [7:0]                   bus_o,
  input  logic                         pll_ck_i,
  input  logic                         pll_en_i,
  output logic                         lock_o,
  output logic                         irq_o
);

  // state      | meaning
  // ST_IDLE    | detector off (EN=0 or PLL disabled), counters held at 0
  // ST_ACQUIRE | windows running, counting consecutive good windows
  // ST_LOCKED  | LOCK_WINDOWS good windows seen; a bad window sets LOSS
  localparam int               WIN_W       = $clog2(WINDOW_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW_LEN - 1);
  localparam logic [3:0]       GOOD_TARGET = 4'(LOCK_WINDOWS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_ck_sync;
  logic [WIN_W-1:0] r_win_cnt, w_win_cnt_nxt;
  logic [7:0]       r_edge_cnt, w_edge_cnt_nxt;
  logic [3:0]       r_good_cnt, w_good_cnt_nxt;
  logic [7:0]       r_ref, r_cnt, w_cnt_nxt;
  logic [2:0]       r_tol;
  logic             r_en, r_loss, r_lock;
  logic             w_loss_set, w_loss_nxt, w_lossie;
  logic             w_edge, w_active, w_wr_lck, w_wr_ref, w_reconf, w_term, w_good;
  logic [7:0]       w_final;
  logic [8:0]       w_diff, w_abs;
  logic             w_unused_ok;

  assign w_edge   = r_ck_sync[1] & ~r_ck_sync[2];
  assign w_active = r_en & pll_en_i;
  assign w_wr_lck = wr_i && (addr_i == PLLLCK_ADDR);
  assign w_wr_ref = wr_i && (addr_i == PLLREF_ADDR);
  // A PLLLCK write only counts as a TOL change when the field value actually changes,
  // so W1C of LOSS or EN/LOSSIE updates do not restart acquisition.
  assign w_reconf = w_wr_ref | (w_wr_lck & (bus_i[6:4] != r_tol));
  assign w_term   = (r_win_cnt == WIN_LAST);

  assign w_final  = (r_edge_cnt == 8'hFF) ? 8'hFF : r_edge_cnt + {7'd0, w_edge};
  assign w_diff   = {1'b0, w_final} - {1'b0, r_ref};
  assign w_abs    = w_diff[8] ? (~w_diff + 9'd1) : w_diff;
  assign w_good   = (w_abs <= {6'd0, r_tol});

  always_comb begin
    w_state_nxt    = r_state;
    w_win_cnt_nxt  = r_win_cnt + 1'b1;
    w_edge_cnt_nxt = w_final;
    w_good_cnt_nxt = r_good_cnt;
    w_cnt_nxt      = r_cnt;
    w_loss_set     = 1'b0;
    if (r_state == ST_IDLE) begin
      w_win_cnt_nxt  = '0;
      w_edge_cnt_nxt = '0;
      w_good_cnt_nxt = '0;
      if (w_active) w_state_nxt = ST_ACQUIRE;
    end else if (!w_active) begin
      w_state_nxt    = ST_IDLE;
      w_win_cnt_nxt  = '0;
      w_edge_cnt_nxt = '0;
      w_good_cnt_nxt = '0;
      w_loss_set     = (r_state == ST_LOCKED);
    end else if (w_reconf) begin
      w_state_nxt    = ST_ACQUIRE;
      w_win_cnt_nxt  = '0;
      w_edge_cnt_nxt = '0;
      w_good_cnt_nxt = '0;
    end else if (w_term) begin
      w_win_cnt_nxt  = '0;
      w_edge_cnt_nxt = '0;
      w_cnt_nxt      = w_final;
      if (w_good) begin
        if (r_state == ST_ACQUIRE) begin
          w_good_cnt_nxt = r_good_cnt + 4'd1;
          if (r_good_cnt + 4'd1 == GOOD_TARGET) w_state_nxt = ST_LOCKED;
        end
      end else begin
        w_good_cnt_nxt = '0;
        if (r_state == ST_LOCKED) begin
          w_state_nxt = ST_ACQUIRE;
          w_loss_set  = 1'b1;
        end
      end
    end
  end

  // Setting LOSS wins over a simultaneous write-1-to-clear.
  assign w_loss_nxt = w_loss_set | (r_loss & ~(w_wr_lck & bus_i[2]));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_ck_sync  <= '0;
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
      r_good_cnt <= '0;
      r_cnt      <= '0;
      r_ref      <= '0;
      r_tol      <= '0;
      r_en       <= 1'b0;
      r_loss     <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ck_sync  <= {r_ck_sync[1:0], pll_ck_i};
      r_win_cnt  <= w_win_cnt_nxt;
      r_edge_cnt <= w_edge_cnt_nxt;
      r_good_cnt <= w_good_cnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_loss     <= w_loss_nxt;
      r_lock     <= (w_state_nxt == ST_LOCKED);
      if (w_wr_ref) r_ref <= bus_i;
      if (w_wr_lck) begin
        r_en  <= bus_i[0];
        r_tol <= bus_i[6:4];
      end
    end
  end

`ifdef ATMEGA_PLL_LOCK_IRQ_EN
  logic r_lossie, r_irq;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lossie <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_lck) r_lossie <= bus_i[3];
      r_irq <= w_loss_nxt & (w_wr_lck ? bus_i[3] : r_lossie);
    end
  end
  assign w_lossie = r_lossie;
  assign irq_o    = r_irq;
`else
  assign w_lossie = 1'b0;
  assign irq_o    = 1'b0;
`endif

  assign lock_o      = r_lock;
  assign w_unused_ok = &{1'b0, bus_i[7], bus_i[3]};

  always_comb begin
    bus_o = 8'h00;
    if (rd_i && !rst_i) begin
      if (addr_i == PLLLCK_ADDR)      bus_o = {1'b0, r_tol, w_lossie, r_loss, r_lock, r_en};
      else if (addr_i == PLLREF_ADDR) bus_o = r_ref;
      else if (addr_i == PLLCNT_ADDR) bus_o = r_cnt;
    end
  end

endmodule

// File: tb/tb_atmega_pll_lock_det.sv
// Bench for atmega_pll_lock_det: a window-level model checks the main instance every cycle;
// a second instance with 1024-cycle windows covers edge-count saturation and PLL disable.
module tb_atmega_pll_lock_det;
  localparam int WL = 256;
  localparam int LW = 4;
`ifdef ATMEGA_PLL_LOCK_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif
  localparam logic [7:0] IE = HAS_IRQ ? 8'h08 : 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        wr, rd;
  logic [7:0]  bus_in, bus_o, bus_o2;
  logic        pll_ck, pll_en, lock_o, irq_o;
  logic        pll_ck2, pll_en2, lock2, irq2;

  int checks = 0;
  int errors = 0;
  int half1  = 0;
  int half2  = 0;

  always #5 clk = ~clk;

  atmega_pll_lock_det #(.WINDOW_LEN(WL), .LOCK_WINDOWS(LW)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wr_i(wr), .rd_i(rd), .bus_i(bus_in),
    .bus_o(bus_o), .pll_ck_i(pll_ck), .pll_en_i(pll_en), .lock_o(lock_o), .irq_o(irq_o));

  atmega_pll_lock_det #(.WINDOW_LEN(1024), .LOCK_WINDOWS(LW)) dut_sat (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wr_i(wr), .rd_i(rd), .bus_i(bus_in),
    .bus_o(bus_o2), .pll_ck_i(pll_ck2), .pll_en_i(pll_en2), .lock_o(lock2), .irq_o(irq2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (main instance) ----------------
  int  m_mode;          // 0 off, 1 acquiring, 2 locked
  int  m_pos, m_edges, m_good, m_cnt, m_ref, m_tol;
  bit  m_en, m_lossie, m_loss;
  bit  m_hist[$];       // [0] newest sample of pll_ck
  bit  e_now, act_now, wl_now, wr_now, rc_now, setl, goodw;
  int  fin;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pos = 0; m_edges = 0; m_good = 0; m_cnt = 0; m_ref = 0; m_tol = 0;
      m_en = 0; m_lossie = 0; m_loss = 0;
      m_hist = '{1'b0, 1'b0, 1'b0};
    end else begin
      e_now = m_hist[1] && !m_hist[2];
      m_hist.push_front(pll_ck);
      void'(m_hist.pop_back());
      act_now = m_en && pll_en;
      wl_now  = wr && (addr == 16'h4A);
      wr_now  = wr && (addr == 16'h4B);
      rc_now  = wr_now || (wl_now && int'(bus_in[6:4]) != m_tol);
      setl    = 0;
      if (m_mode == 0) begin
        if (act_now) begin m_mode = 1; m_pos = 0; m_edges = 0; m_good = 0; end
      end else if (!act_now) begin
        setl = (m_mode == 2);
        m_mode = 0; m_pos = 0; m_edges = 0; m_good = 0;
      end else if (rc_now) begin
        m_mode = 1; m_pos = 0; m_edges = 0; m_good = 0;
      end else if (m_pos == WL - 1) begin
        fin = m_edges + int'(e_now);
        if (fin > 255) fin = 255;
        m_cnt = fin;
        goodw = (fin - m_ref <= m_tol) && (m_ref - fin <= m_tol);
        m_pos = 0; m_edges = 0;
        if (goodw) begin
          if (m_mode == 1) begin
            m_good++;
            if (m_good == LW) m_mode = 2;
          end
        end else begin
          m_good = 0;
          if (m_mode == 2) begin m_mode = 1; setl = 1; end
        end
      end else begin
        m_pos++;
        m_edges += int'(e_now);
      end
      if (wl_now) begin
        m_en = bus_in[0]; m_tol = int'(bus_in[6:4]); m_lossie = HAS_IRQ && bus_in[3];
      end
      if (wr_now) m_ref = int'(bus_in);
      m_loss = setl || (m_loss && !(wl_now && bus_in[2]));
    end
  end

  function automatic logic [7:0] exp_bus();
    logic [7:0] v;
    v = 8'h00;
    if (rd && !rst) begin
      if (addr == 16'h4A)
        v = {1'b0, 3'(m_tol), m_lossie, m_loss, (m_mode == 2), m_en};
      else if (addr == 16'h4B) v = 8'(m_ref);
      else if (addr == 16'h4C) v = 8'(m_cnt);
    end
    return v;
  endfunction

  always @(negedge clk) begin
    check("lock_o", lock_o, (m_mode == 2));
    check("irq_o", irq_o, HAS_IRQ && m_loss && m_lossie);
    check("bus_o", bus_o, exp_bus());
  end

  // ---------------- PLL clock sources (clk-synchronous, phase >= 1 clk) ----------------
  initial begin
    int c1 = 0;
    int c2 = 0;
    pll_ck = 1'b0; pll_ck2 = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (half1 > 0) begin c1++; if (c1 >= half1) begin c1 = 0; pll_ck = ~pll_ck; end end
      if (half2 > 0) begin c2++; if (c2 >= half2) begin c2 = 0; pll_ck2 = ~pll_ck2; end end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    addr = a; bus_in = d; wr = 1'b1; rd = 1'b0;
    @(negedge clk); #1;
    wr = 1'b0; addr = 16'h4C; rd = 1'b1; bus_in = 8'h00;
  endtask

  task automatic rd_reg(input logic [15:0] a, output logic [7:0] v, output logic [7:0] v2);
    addr = a; rd = 1'b1; #1;
    v = bus_o; v2 = bus_o2;
    addr = 16'h4C;
  endtask

  // n = cycles (negedges) until the selected lock output equals want
  task automatic wait_lock(input bit sat, input logic want, input int limit, output int n);
    n = 0;
    while (((sat ? lock2 : lock_o) !== want) && n < limit) begin
      @(negedge clk); #1; n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v, v2;
    int n;
    bit seen;
    rst = 1'b1; addr = 16'h4C; wr = 1'b0; rd = 1'b1; bus_in = 8'h00;
    pll_en = 1'b0; pll_en2 = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // reset values
    rd_reg(16'h4A, v, v2); check("rst PLLLCK", v, 8'h00);
    rd_reg(16'h4B, v, v2); check("rst PLLREF", v, 8'h00);
    rd_reg(16'h4C, v, v2); check("rst PLLCNT", v, 8'h00);
    check("rst lock_o", lock_o, 1'b0);
    check("rst irq_o", irq_o, 1'b0);

    // lock acquisition: period 8 -> 32 edges per 256-cycle window
    pll_en = 1'b1; half1 = 4; cyc(20);
    wr_reg(16'h4B, 8'd32);
    wr_reg(16'h4A, 8'h11 | IE);
    wait_lock(0, 1'b1, 2000, n);
    check("acq lock cycles", n, 1025);
    rd_reg(16'h4C, v, v2); check("acq PLLCNT", v, 8'd32);

    // loss of lock: period 10 -> ~25 edges per window
    half1 = 5;
    wait_lock(0, 1'b0, 1000, n);
    check("loss lock drop", lock_o, 1'b0);
    rd_reg(16'h4A, v, v2); check("loss PLLLCK", v, 8'h15 | IE);
    check("loss irq_o", irq_o, HAS_IRQ);
    rd_reg(16'h4C, v, v2); check("loss PLLCNT<=30", (v <= 8'd30), 1'b1);
    wr_reg(16'h4A, 8'h15 | IE);
    rd_reg(16'h4A, v, v2); check("w1c PLLLCK", v, 8'h11 | IE);
    check("w1c irq_o", irq_o, 1'b0);

    // tolerance boundary: ref 30 tol 2 with count 32 is good
    half1 = 4; cyc(20);
    wr_reg(16'h4B, 8'd30);
    wr_reg(16'h4A, 8'h21 | IE);
    wait_lock(0, 1'b1, 2000, n);
    check("tol2 lock cycles", n, 1024);
    rd_reg(16'h4C, v, v2); check("tol2 PLLCNT", v, 8'd32);
    wr_reg(16'h4B, 8'd29);
    seen = 0;
    for (int i = 0; i < 6 * WL; i++) begin
      cyc(1);
      if (lock_o === 1'b1) seen = 1;
    end
    check("ref29 never locks", seen, 1'b0);
    rd_reg(16'h4A, v, v2); check("ref29 PLLLCK", v, 8'h21 | IE);
    rd_reg(16'h4C, v, v2); check("ref29 PLLCNT", v, 8'd32);

    // restart on reconfiguration while locked
    wr_reg(16'h4A, 8'h11 | IE);
    wr_reg(16'h4B, 8'd32);
    wait_lock(0, 1'b1, 2000, n);
    check("relock cycles", n, 1024);
    wr_reg(16'h4B, 8'd32);
    check("reconf lock drop", lock_o, 1'b0);
    wait_lock(0, 1'b1, 2000, n);
    check("reconf relock cycles", n, 1024);
    rd_reg(16'h4A, v, v2); check("reconf PLLLCK", v, 8'h13 | IE);

    // asynchronous reset mid-window
    addr = 16'h4A; rd = 1'b1;
    @(negedge clk); #3;
    rst = 1'b1; #1;
    check("arst lock_o", lock_o, 1'b0);
    check("arst irq_o", irq_o, 1'b0);
    check("arst bus_o", bus_o, 8'h00);
    addr = 16'h4C;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    rd_reg(16'h4C, v, v2); check("arst PLLCNT", v, 8'h00);

    // saturation (1024-cycle window, period 2) and PLL disable while locked
    pll_en2 = 1'b1; half2 = 1; cyc(10);
    wr_reg(16'h4B, 8'd255);
    wr_reg(16'h4A, 8'h01 | IE);
    wait_lock(1, 1'b1, 5000, n);
    check("sat lock cycles", n, 4097);
    rd_reg(16'h4C, v, v2); check("sat PLLCNT", v2, 8'd255);
    pll_en2 = 1'b0;
    cyc(1);
    check("dis lock2", lock2, 1'b0);
    rd_reg(16'h4A, v, v2); check("dis PLLLCK", v2, 8'h05 | IE);
    check("dis irq2", irq2, HAS_IRQ);
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
